// File: rtl/game_pkg.sv
// game_pkg: shared game mode/match state types and match timing defaults
package game_pkg;
    typedef enum logic [1:0] {START, GAME, PLAYER1_WIN, PLAYER2_WIN} game_mode_t;
    typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, POINT_PAUSE, MATCH_END} match_state_t;
    localparam int DEF_FRAMES_PER_SEC = 60;
    localparam int COUNTDOWN_SEC = 3;
    localparam int POINT_PAUSE_FRAMES = 90;
    localparam int MATCH_WIN_SCORE = 3;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/match_scheduler_frame_divider.sv
// frame_divider: counts frame ticks while enabled and pulses tc on the tick that reaches limit
module frame_divider #(
    parameter int N = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     tick,
    input  logic [$clog2(N+1)-1:0]   limit,
    output logic                     tc
);
    localparam int W = $clog2(N + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tc = en && tick && (cnt_q + W'(1) == limit);
        cnt_d = (clr || tc) ? '0 : (en && tick) ? cnt_q + W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/match_scheduler.sv
// match_scheduler: round/match sequencer running countdown, play, point pause and match end
module match_scheduler
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int COUNT_SEC      = COUNTDOWN_SEC,
    parameter int PAUSE_FRAMES   = POINT_PAUSE_FRAMES,
    parameter int WIN_SCORE      = MATCH_WIN_SCORE
) (
    input  logic       clk,
    input  logic       rst,
    input  game_mode_t mode,
    input  logic       frame_tick,
    input  logic       player1_collision,
    input  logic       player2_collision,
    output logic       move_en,
    output logic       round_restart,
    output logic [1:0] countdown,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       match_p1_win,
    output logic       match_p2_win
);
    localparam int DIV_N = max_int(FRAMES_PER_SEC, PAUSE_FRAMES);
    localparam int DW = $clog2(DIV_N + 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [1:0] CD = 2'(COUNT_SEC);

    match_state_t state_q, state_d;
    logic [1:0] countdown_q, countdown_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d;
    logic move_en_q, move_en_d, round_restart_q, round_restart_d;
    logic p1_win_q, p1_win_d, p2_win_q, p2_win_d;
    logic tc, counting;
    logic [DW-1:0] limit;

    // One divider serves both counting states; the limit follows the current state.
    assign counting = (state_q == COUNTDOWN) || (state_q == POINT_PAUSE);
    assign limit = (state_q == POINT_PAUSE) ? DW'(PAUSE_FRAMES) : DW'(FRAMES_PER_SEC);

    frame_divider #(.N(DIV_N)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .en   (counting),
        .tick (frame_tick),
        .limit(limit),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        countdown_d = countdown_q;
        score1_d = score1_q;
        score2_d = score2_q;
        move_en_d = 1'b0;
        round_restart_d = 1'b0;
        p1_win_d = p1_win_q;
        p2_win_d = p2_win_q;
        if (mode != GAME) begin
            state_d = IDLE;
            countdown_d = '0;
            score1_d = '0;
            score2_d = '0;
            p1_win_d = 1'b0;
            p2_win_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNTDOWN;
                    round_restart_d = 1'b1;
                    countdown_d = CD;
                    score1_d = '0;
                    score2_d = '0;
                    p1_win_d = 1'b0;
                    p2_win_d = 1'b0;
                end
                COUNTDOWN: if (tc) begin
                    countdown_d = countdown_q - 2'd1;
                    state_d = (countdown_q == 2'd1) ? PLAY : COUNTDOWN;
                    move_en_d = (countdown_q == 2'd1);
                end
                PLAY: begin
                    move_en_d = !(player1_collision || player2_collision);
                    state_d = (player1_collision || player2_collision) ? POINT_PAUSE : PLAY;
                    // A simultaneous crash is a draw and scores nothing.
                    if (player1_collision && !player2_collision && score2_q < WIN)
                        score2_d = score2_q + 4'd1;
                    if (player2_collision && !player1_collision && score1_q < WIN)
                        score1_d = score1_q + 4'd1;
                end
                POINT_PAUSE: if (tc) begin
                    if (score1_q == WIN || score2_q == WIN) begin
                        state_d = MATCH_END;
                        p1_win_d = (score1_q == WIN);
                        p2_win_d = (score2_q == WIN);
                    end else begin
                        state_d = COUNTDOWN;
                        round_restart_d = 1'b1;
                        countdown_d = CD;
                    end
                end
                MATCH_END: state_d = MATCH_END;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            countdown_q <= '0;
            score1_q <= '0;
            score2_q <= '0;
            move_en_q <= 1'b0;
            round_restart_q <= 1'b0;
            p1_win_q <= 1'b0;
            p2_win_q <= 1'b0;
        end else begin
            state_q <= state_d;
            countdown_q <= countdown_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            move_en_q <= move_en_d;
            round_restart_q <= round_restart_d;
            p1_win_q <= p1_win_d;
            p2_win_q <= p2_win_d;
        end
    end

    assign move_en = move_en_q;
    assign round_restart = round_restart_q;
    assign countdown = countdown_q;
    assign score1 = score1_q;
    assign score2 = score2_q;
    assign match_p1_win = p1_win_q;
    assign match_p2_win = p2_win_q;
endmodule

// File: tb/tb_match_scheduler.sv
// tb_match_scheduler: directed and random stimulus checked against a phase/tick-count model
module tb_match_scheduler;
    import game_pkg::*;
    localparam int FPS = 2, CS = 3, PF = 2, WS = 3;
    logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, p1c = 1'b0, p2c = 1'b0;
    game_mode_t mode = START;
    logic move_en, round_restart, match_p1_win, match_p2_win;
    logic [1:0] countdown;
    logic [3:0] score1, score2;
    int total = 0, bad = 0;
    int ph = 0, ticks = 0, s1 = 0, s2 = 0;
    bit e_rr = 1'b0;

    always #5 clk = ~clk;

    match_scheduler #(.FRAMES_PER_SEC(FPS), .COUNT_SEC(CS), .PAUSE_FRAMES(PF), .WIN_SCORE(WS)) dut (
        .clk(clk), .rst(rst), .mode(mode), .frame_tick(frame_tick),
        .player1_collision(p1c), .player2_collision(p2c),
        .move_en(move_en), .round_restart(round_restart), .countdown(countdown),
        .score1(score1), .score2(score2),
        .match_p1_win(match_p1_win), .match_p2_win(match_p2_win)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ph: 0 idle, 1 countdown, 2 play, 3 pause, 4 match end; ticks counted within the phase
    task automatic model();
        e_rr = 1'b0;
        if (rst || mode != GAME) begin
            ph = 0; ticks = 0; s1 = 0; s2 = 0;
        end else begin
            case (ph)
                0: begin ph = 1; ticks = 0; s1 = 0; s2 = 0; e_rr = 1'b1; end
                1: if (frame_tick) begin
                    ticks++;
                    if (ticks == CS * FPS) begin ph = 2; ticks = 0; end
                end
                2: if (p1c || p2c) begin
                    if (p1c && !p2c && s2 < WS) s2++;
                    if (p2c && !p1c && s1 < WS) s1++;
                    ph = 3; ticks = 0;
                end
                3: if (frame_tick) begin
                    ticks++;
                    if (ticks == PF) begin
                        ticks = 0;
                        if (s1 == WS || s2 == WS) ph = 4;
                        else begin ph = 1; e_rr = 1'b1; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        chk("move_en", move_en, int'(ph == 2));
        chk("round_restart", round_restart, int'(e_rr));
        chk("countdown", countdown, (ph == 1) ? CS - ticks / FPS : 0);
        chk("score1", score1, s1);
        chk("score2", score2, s2);
        chk("match_p1_win", match_p1_win, int'(ph == 4 && s1 == WS));
        chk("match_p2_win", match_p2_win, int'(ph == 4 && s2 == WS));
    endtask

    task automatic step(input bit t, input bit c1, input bit c2);
        frame_tick = t; p1c = c1; p2c = c2;
        @(posedge clk);
        model();
        #1;
        check_all();
        frame_tick = 1'b0; p1c = 1'b0; p2c = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        step(0, 0, 0);
        step(0, 0, 0);
        chk("lit_rst_move", move_en, 0);
        chk("lit_rst_cd", countdown, 0);
        rst = 1'b0; mode = GAME;
        step(0, 0, 0);
        chk("lit_start_rr", round_restart, 1);
        chk("lit_start_cd", countdown, 3);
        step(0, 1, 1);
        chk("lit_rr_pulse", round_restart, 0);
        tick_n(2);
        chk("lit_cd2", countdown, 2);
        tick_n(2);
        chk("lit_cd1", countdown, 1);
        tick_n(2);
        chk("lit_play_move", move_en, 1);
        chk("lit_play_cd", countdown, 0);
        step(0, 1, 0);
        chk("lit_p1_score2", score2, 1);
        chk("lit_pause_move", move_en, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("lit_restart_rr", round_restart, 1);
        chk("lit_restart_cd", countdown, 3);
        tick_n(CS * FPS);
        step(0, 1, 1);
        chk("lit_draw_s1", score1, 0);
        chk("lit_draw_s2", score2, 1);
        tick_n(PF);
        tick_n(CS * FPS);
        for (int r = 0; r < 3; r++) begin
            step(0, 0, 1);
            step(1, 1, 0);
            step(0, 1, 1);
            step(1, 0, 1);
            if (r < 2) tick_n(CS * FPS);
        end
        chk("lit_end_s1", score1, 3);
        chk("lit_end_w1", match_p1_win, 1);
        chk("lit_end_w2", match_p2_win, 0);
        for (int i = 0; i < 6; i++) step(1'(i), 1'b1, 1'(i >> 1));
        chk("lit_end_hold", match_p1_win, 1);
        chk("lit_end_s2", score2, 1);
        rst = 1'b1;
        step(0, 0, 0);
        chk("lit_rst_end_w1", match_p1_win, 0);
        chk("lit_rst_end_s1", score1, 0);
        rst = 1'b0;
        step(0, 0, 0);
        chk("lit_after_rst_cd", countdown, 3);
        tick_n(3);
        mode = START;
        step(0, 0, 0);
        chk("lit_abort_cd", countdown, 0);
        mode = GAME;
        step(0, 0, 0);
        chk("lit_regame_cd", countdown, 3);
        tick_n(CS * FPS);
        step(0, 0, 1);
        tick_n(PF);
        tick_n(CS * FPS);
        mode = START;
        step(0, 0, 0);
        chk("lit_abort_play_move", move_en, 0);
        chk("lit_abort_play_s1", score1, 0);
        mode = GAME;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0)
                mode = (mode == GAME) ? game_mode_t'($urandom_range(0, 1) ? PLAYER1_WIN : START) : GAME;
            step(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
